process_clk_meter: RTL and testbench
====================================

PROCESS_CLK_METER -- requirements
Module: process_clk_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of all cycle-count values.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 0, abort threshold in cycles; 0 disables timeout.
REQ-003 SHALL have port ACLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port ARESETN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port arm  input  1  one-cycle pulse from AXI4-Lite register bank, enables one measurement.
REQ-006 SHALL have port clear  input  1  one-cycle pulse from register bank, clears statistics and flags.
REQ-007 SHALL have port proc_start  input  1  pulse from processing engine marking start of work.
REQ-008 SHALL have port proc_done  input  1  pulse from processing engine marking end of work.
REQ-009 SHALL have port state_o  output  2  FSM state: 0 IDLE, 1 ARMED, 2 MEASURE, 3 DONE.
REQ-010 SHALL have port cur_count  output  CNT_W  running count of the active measurement.
REQ-011 SHALL have port last_count  output  CNT_W  result of the most recent completed measurement.
REQ-012 SHALL have port max_count  output  CNT_W  largest completed result since clear.
REQ-013 SHALL have port min_count  output  CNT_W  smallest completed result since clear.
REQ-014 SHALL have port run_count  output  16  completed measurements since clear.
REQ-015 SHALL have port overflow  output  1  sticky, a count saturated.
REQ-016 SHALL have port timeout  output  1  sticky, a measurement aborted by timeout.
REQ-017 SHALL have port result_valid  output  1  one-cycle pulse when statistics update.

Function
REQ-018 SHALL leave IDLE for ARMED only on arm=1 sampled in IDLE; arm in any other state is ignored.
REQ-019 SHALL, in ARMED, on proc_start=1, load cur_count with 0 and enter MEASURE; proc_done in ARMED is ignored, including when simultaneous with proc_start.
REQ-020 SHALL, in MEASURE with proc_done=0, increment cur_count by 1 per cycle, saturating at all-ones and setting overflow on the saturating cycle.
REQ-021 SHALL, in MEASURE with proc_done=1, register measured value M = cur_count+1 (saturated; sets overflow if saturated), enter DONE; proc_start at edge t and proc_done at edge t+N gives M=N.
REQ-022 SHALL, on the MEASURE-to-DONE edge, write last_count=M, max_count=max(max_count,M), min_count=min(min_count,M), run_count+1 (saturating at 0xFFFF).
REQ-023 SHALL assert result_valid for exactly the one cycle state_o=3, then return to IDLE.
REQ-024 SHALL, when TIMEOUT_CYCLES!=0 and cur_count+1 reaches TIMEOUT_CYCLES in MEASURE without proc_done, set timeout, return to IDLE, leave statistics unchanged, no result_valid.
REQ-025 SHALL, on clear=1, in any state, next cycle force IDLE, cur_count/last_count/max_count/run_count=0, min_count=all-ones, overflow=timeout=0, result_valid=0; clear has priority over all other inputs.
REQ-026 SHALL hold cur_count at its last value in IDLE, ARMED and DONE.
REQ-027 SHALL drive all outputs directly from registers; no combinational input-to-output paths.

Reset
REQ-028 SHALL, while ARESETN=0, asynchronously force state IDLE, all counts 0 except min_count=all-ones, all flags and result_valid 0.
REQ-029 SHALL, on ARESETN deasserting mid-measurement, remain IDLE until a new arm; no partial result is recorded.

Verification
REQ-030 Reset, arm, proc_start@t, proc_done@t+10 -> result_valid one cycle, last=max=min=10, run_count=1.
REQ-031 Three runs N=5,20,8 -> last=8, max=20, min=5, run_count=3, three result_valid pulses.
REQ-032 TIMEOUT_CYCLES=16, arm, proc_start, no proc_done -> after 16 cycles timeout=1, state IDLE, run_count unchanged, no result_valid.
REQ-033 clear during MEASURE at count 7 -> next cycle IDLE, all stats 0, min=all-ones, later proc_done ignored.
REQ-034 CNT_W=4, run N=20 -> cur_count saturates at 15, overflow=1, last_count=15; proc_start+proc_done same cycle in ARMED -> MEASURE entered, done ignored.
REQ-035 arm while MEASURE, proc_start while IDLE -> no state change, no stat update.

Source files
------------

// File: rtl/process_clk_meter.sv
// Cycle-count meter for a processing engine: measures proc_start-to-proc_done latency
// once per arm, and keeps last/max/min/run statistics plus sticky overflow and timeout flags.
module process_clk_meter #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             arm,
   input  logic             clear,
   input  logic             proc_start,
   input  logic             proc_done,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] cur_count,
   output logic [CNT_W-1:0] last_count,
   output logic [CNT_W-1:0] max_count,
   output logic [CNT_W-1:0] min_count,
   output logic [15:0]      run_count,
   output logic             overflow,
   output logic             timeout,
   output logic             result_valid
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W:0]   TIMEOUT_VAL = (CNT_W+1)'(TIMEOUT_CYCLES);
   localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

   state_t           state;
   logic [CNT_W:0]   cur_inc;
   logic             cur_sat;
   logic [CNT_W-1:0] next_count;

   // One extra bit on the increment lets the timeout compare see the unsaturated value.
   assign cur_inc    = {1'b0, cur_count} + {{CNT_W{1'b0}}, 1'b1};
   assign cur_sat    = (cur_count == CNT_MAX);
   assign next_count = cur_sat ? CNT_MAX : cur_inc[CNT_W-1:0];
   assign state_o    = state;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state        <= IDLE;
         cur_count    <= '0;
         last_count   <= '0;
         max_count    <= '0;
         min_count    <= CNT_MAX;
         run_count    <= '0;
         overflow     <= 1'b0;
         timeout      <= 1'b0;
         result_valid <= 1'b0;
      end else if (clear) begin
         state        <= IDLE;
         cur_count    <= '0;
         last_count   <= '0;
         max_count    <= '0;
         min_count    <= CNT_MAX;
         run_count    <= '0;
         overflow     <= 1'b0;
         timeout      <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (arm) state <= ARMED;
            end
            ARMED: begin
               if (proc_start) begin
                  cur_count <= '0;
                  state     <= MEASURE;
               end
            end
            MEASURE: begin
               // proc_done wins over a timeout landing on the same cycle.
               if (proc_done) begin
                  last_count <= next_count;
                  if (next_count > max_count) max_count <= next_count;
                  if (next_count < min_count) min_count <= next_count;
                  if (run_count != 16'hFFFF) run_count <= run_count + 16'd1;
                  if (cur_sat) overflow <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  cur_count <= next_count;
                  if (cur_sat) overflow <= 1'b1;
                  if (TIMEOUT_EN && (cur_inc >= TIMEOUT_VAL)) begin
                     timeout <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_process_clk_meter.sv
// Bench for process_clk_meter: a saturating 4-bit instance and a 32-bit instance with a
// 16-cycle timeout share one stimulus stream; expectations come from per-run arithmetic.
module tb_process_clk_meter;

   logic ACLK;
   logic ARESETN;
   logic arm, clear, proc_start, proc_done;

   logic [1:0]  state_a, state_b;
   logic [3:0]  cur_a, last_a, max_a, min_a;
   logic [31:0] cur_b, last_b, max_b, min_b;
   logic [15:0] run_a, run_b;
   logic        ovf_a, ovf_b, to_a, to_b, rv_a, rv_b;

   int checks = 0;
   int failures = 0;
   int pulses_a = 0, pulses_b = 0;
   int exp_pulses_a = 0, exp_pulses_b = 0;
   int qa[$];
   int qb[$];
   bit exp_ovf_a = 0;
   bit exp_to_b = 0;

   process_clk_meter #(.CNT_W(4), .TIMEOUT_CYCLES(0)) dut_sat (
      .ACLK(ACLK), .ARESETN(ARESETN), .arm(arm), .clear(clear),
      .proc_start(proc_start), .proc_done(proc_done), .state_o(state_a),
      .cur_count(cur_a), .last_count(last_a), .max_count(max_a), .min_count(min_a),
      .run_count(run_a), .overflow(ovf_a), .timeout(to_a), .result_valid(rv_a)
   );

   process_clk_meter #(.CNT_W(32), .TIMEOUT_CYCLES(16)) dut_to (
      .ACLK(ACLK), .ARESETN(ARESETN), .arm(arm), .clear(clear),
      .proc_start(proc_start), .proc_done(proc_done), .state_o(state_b),
      .cur_count(cur_b), .last_count(last_b), .max_count(max_b), .min_count(min_b),
      .run_count(run_b), .overflow(ovf_b), .timeout(to_b), .result_valid(rv_b)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   always @(negedge ACLK) begin
      if (rv_a) pulses_a++;
      if (rv_b) pulses_b++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check_states(input int sa, input int sb);
      check_output("a_state", 64'(state_a), 64'(sa));
      check_output("b_state", 64'(state_b), 64'(sb));
   endtask

   // Expected statistics derived from the list of completed results since clear/reset.
   task automatic check_stats();
      longint mx_a = 0, mn_a = 15, mx_b = 0, mn_b = 64'hFFFF_FFFF;
      longint ls_a = 0, ls_b = 0;
      foreach (qa[i]) begin
         if (qa[i] > mx_a) mx_a = qa[i];
         if (qa[i] < mn_a) mn_a = qa[i];
      end
      foreach (qb[i]) begin
         if (qb[i] > mx_b) mx_b = qb[i];
         if (qb[i] < mn_b) mn_b = qb[i];
      end
      if (qa.size() > 0) ls_a = qa[qa.size()-1];
      if (qb.size() > 0) ls_b = qb[qb.size()-1];
      check_output("a_last", 64'(last_a), 64'(ls_a));
      check_output("a_max", 64'(max_a), 64'(mx_a));
      check_output("a_min", 64'(min_a), 64'(mn_a));
      check_output("a_run", 64'(run_a), 64'(qa.size()));
      check_output("a_overflow", 64'(ovf_a), 64'(exp_ovf_a));
      check_output("a_timeout", 64'(to_a), 64'(0));
      check_output("b_last", 64'(last_b), 64'(ls_b));
      check_output("b_max", 64'(max_b), 64'(mx_b));
      check_output("b_min", 64'(min_b), 64'(mn_b));
      check_output("b_run", 64'(run_b), 64'(qb.size()));
      check_output("b_overflow", 64'(ovf_b), 64'(0));
      check_output("b_timeout", 64'(to_b), 64'(exp_to_b));
   endtask

   task automatic forget_history();
      qa.delete();
      qb.delete();
      exp_ovf_a = 0;
      exp_to_b = 0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      forget_history();
      check_states(0, 0);
      check_output("a_cur_clr", 64'(cur_a), 64'(0));
      check_output("b_cur_clr", 64'(cur_b), 64'(0));
      check_output("a_rv_clr", 64'(rv_a), 64'(0));
      check_stats();
   endtask

   // One measurement of n cycles; optional simultaneous done in ARMED and idle gap.
   task automatic apply_stimulus(input int n, input bit same_done, input int gap);
      bit b_alive = 1;
      int m_a;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check_states(1, 1);
      repeat (gap) tick();
      proc_start = 1'b1;
      proc_done  = same_done;
      tick();
      proc_start = 1'b0;
      proc_done  = 1'b0;
      check_states(2, 2);
      check_output("a_cur_start", 64'(cur_a), 64'(0));
      for (int k = 1; k < n; k++) begin
         if (n > 2 && k == n / 2 && k < 16) arm = 1'b1;
         tick();
         arm = 1'b0;
         if (b_alive && k == 16) begin
            b_alive  = 0;
            exp_to_b = 1;
            check_output("b_state_to", 64'(state_b), 64'(0));
            check_output("b_timeout_flag", 64'(to_b), 64'(1));
         end
      end
      check_output("a_state_run", 64'(state_a), 64'(2));
      check_output("a_cur_run", 64'(cur_a), 64'((n - 1 > 15) ? 15 : n - 1));
      if (b_alive) check_output("b_cur_run", 64'(cur_b), 64'(n - 1));
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      m_a = (n > 15) ? 15 : n;
      if (n > 15) exp_ovf_a = 1;
      qa.push_back(m_a);
      exp_pulses_a++;
      check_output("a_state_done", 64'(state_a), 64'(3));
      check_output("a_rv_done", 64'(rv_a), 64'(1));
      if (b_alive) begin
         qb.push_back(n);
         exp_pulses_b++;
         check_output("b_state_done", 64'(state_b), 64'(3));
         check_output("b_rv_done", 64'(rv_b), 64'(1));
      end else begin
         check_output("b_state_late_done", 64'(state_b), 64'(0));
         check_output("b_rv_late_done", 64'(rv_b), 64'(0));
      end
      check_stats();
      tick();
      check_states(0, 0);
      check_output("a_rv_after", 64'(rv_a), 64'(0));
      check_output("b_rv_after", 64'(rv_b), 64'(0));
   endtask

   initial begin
      ARESETN = 1'b0;
      arm = 1'b0; clear = 1'b0; proc_start = 1'b0; proc_done = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      check_states(0, 0);
      check_output("a_cur_rst", 64'(cur_a), 64'(0));
      check_output("a_rv_rst", 64'(rv_a), 64'(0));
      check_stats();
      #3 ARESETN = 1'b1;
      tick();

      apply_stimulus(10, 0, 0);
      do_clear();
      apply_stimulus(5, 0, 1);
      apply_stimulus(20, 0, 0);
      apply_stimulus(8, 1, 2);

      // Inputs that must be ignored while IDLE.
      proc_start = 1'b1;
      tick();
      proc_start = 1'b0;
      check_states(0, 0);
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      check_states(0, 0);
      check_stats();

      apply_stimulus(1, 1, 0);
      apply_stimulus(16, 0, 0);
      apply_stimulus(17, 0, 0);
      apply_stimulus(30, 1, 1);

      repeat (14) begin
         apply_stimulus($urandom_range(1, 40), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) do_clear();
      end

      // Clear in the middle of a measurement, then a stray done.
      arm = 1'b1; tick(); arm = 1'b0;
      proc_start = 1'b1; tick(); proc_start = 1'b0;
      repeat (7) tick();
      check_output("a_cur_7", 64'(cur_a), 64'(7));
      check_output("b_cur_7", 64'(cur_b), 64'(7));
      do_clear();
      proc_done = 1'b1; tick(); proc_done = 1'b0;
      check_states(0, 0);
      check_stats();

      // Reset in the middle of a measurement, then a stray done.
      apply_stimulus(12, 0, 0);
      arm = 1'b1; tick(); arm = 1'b0;
      proc_start = 1'b1; tick(); proc_start = 1'b0;
      repeat (5) tick();
      ARESETN = 1'b0;
      #2;
      forget_history();
      check_states(0, 0);
      check_stats();
      ARESETN = 1'b1;
      tick();
      proc_done = 1'b1; tick(); proc_done = 1'b0;
      check_states(0, 0);
      check_stats();
      tick();

      check_output("a_pulses", 64'(pulses_a), 64'(exp_pulses_a));
      check_output("b_pulses", 64'(pulses_b), 64'(exp_pulses_b));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
